sdr_fifo_port: RTL
==================

// Module: sdr_fifo_port
// PURPOSE
//  Parametrised successor to the single-byte serial data register: bidirectional CNT/SP serial port
//  with TX and RX FIFOs, programmable bit rate, configurable frame width and bit order.
//  Sits behind the cartridge I/O decode (cs = $FD9x window) on the Plus4 bus. All logic runs
//  on E_CLK (Phi0); CNT is synchronised internally, so there is no second clock domain.
// PARAMETERS
//  WIDTH      8  bits per serial frame, 1..8; D[WIDTH-1:0] carries data, upper bits read 0
//  TX_DEPTH   4  TX FIFO entries, power of two, >=2
//  RX_DEPTH   4  RX FIFO entries, power of two, >=2
//  DIV_W      8  width of half-bit divider register
//  MSB_FIRST  1  1: shift MSB first (legacy CIA order); 0: LSB first
// PORTS
//  E_CLK      in   1  only clock (Phi0); all state on rising edge
//  RESET_n    in   1  asynchronous active-low reset
//  cs         in   1  block selected (address decode done outside)
//  RW         in   1  1 read, 0 write; an access lasts exactly one E_CLK cycle with cs=1
//  A          in   2  register select
//  d_in       in   8  write data
//  d_out      out  8  read data (combinational from registers/FIFO head)
//  d_oe       out  1  = cs && RW; top level drives D when set and MUX=0
//  cnt_in     in   1  CNT pin level
//  cnt_oe     out  1  1 = pull CNT low (open drain)
//  sp_in      in   1  SP pin level
//  sp_oe      out  1  1 = pull SP low (open drain)
//  irq_n      out  1  active-low interrupt, level
// BEHAVIOUR
//  Registers: A=0 DATA  W: push TX FIFO; R: head of RX FIFO, pop on read (reads 0 if empty, no pop)
//   A=1 CTRL  W: [6]=dir_out, [5]=irq_en, [0]=flush; R: [7]=irq, [6]=dir_out, [5]=irq_en,
//       [4]=done, [3]=rx_ovf, [2]=tx_full, [1]=rx_avail, [0]=busy. Write clears done, rx_ovf.
//   A=2 DIV   R/W half-bit period minus 1 (D[DIV_W-1:0]); A=3 reserved, reads 0, writes ignored.
//  Reset: FIFOs empty, dir_out=0, irq_en=0, DIV=0, flags 0, cnt_oe=0, sp_oe=0, irq_n=1, d_out=0.
//  Write to CTRL with flush=1 or dir_out changed: both FIFOs emptied, shifter to IDLE, pins released.
//  TX FSM (dir_out=1): IDLE -> LOAD when TX non-empty: pop word, bit_cnt=0 -> LOW: cnt_oe=1, sp_oe=!bit,
//   hold DIV+1 cycles -> HIGH: cnt_oe=0, hold DIV+1 cycles, bit_cnt++ -> LOW or, at bit_cnt=WIDTH,
//   set done -> LOAD if TX non-empty (no gap cycle) else IDLE (sp_oe=0). DIV=0: 2 cycles/bit.
//  RX (dir_out=0): cnt_in, sp_in through 2-flop sync; rising edge of synced CNT shifts synced SP in;
//   after WIDTH bits push word, set done. RX full at push: word dropped, rx_ovf=1, FIFO unchanged.
//  Frame alignment: bit counter resets on flush/dir change only; partial frame persists across idle.
//  TX push when full: ignored, tx_full stays 1. Simultaneous push and internal pop same cycle on
//   full TX FIFO: pop first, push accepted. Simultaneous RX push and bus pop: both happen.
//  irq = irq_en && (done || rx_ovf); irq_n = !irq registered, 1 cycle after flag sets.
//  busy = TX FSM not IDLE or TX FIFO non-empty (dir_out=1); partial RX frame (dir_out=0).
//  Reset asserted mid-frame: pins released immediately (async), partial frame lost.
// STRUCTURE
//  Package sdr_pkg: register address constants, CTRL bit positions, TX FSM state enum.
//  Sub-module sdr_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/head, instantiated twice (TX, RX).
//  Top holds register file, TX FSM + divider counter, RX synchroniser/shifter, IRQ logic.
// TESTING
//  Reset, then read CTRL,DIV -> 8'h00, 8'h00; irq_n=1, cnt_oe=sp_oe=0.
//  dir_out=1, DIV=3, write $A5 -> 8 CNT low pulses of 4 cycles, period 8; SP low on bits 0 of
//   1010_0101 MSB first; done=1 after last high phase; irq_n=0 only if irq_en=1.
//  dir_out=1, write 5 words into 4-deep TX quickly -> 5th write dropped unless a pop occurred;
//   back-to-back frames with no idle cycle between last HIGH and next LOW.
//  dir_out=0, drive 8 CNT rising edges with SP=$3C bits -> rx_avail=1, DATA read $3C, rx_avail=0.
//  dir_out=0, send 5 frames without reading (RX_DEPTH=4) -> rx_ovf=1, reads return frames 1-4.
//  WIDTH=5, MSB_FIRST=0: write $13 -> SP pattern 1,1,0,0,1; mid-frame dir flip -> pins released,
//   FIFOs empty, busy=0 next cycle.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared constants for the CNT/SP serial port: register map,
// CTRL bit positions and the transmit shifter state encoding.
package sdr_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;

    localparam int CTRL_IRQ   = 7;
    localparam int CTRL_DIR   = 6;
    localparam int CTRL_IEN   = 5;
    localparam int CTRL_DONE  = 4;
    localparam int CTRL_OVF   = 3;
    localparam int CTRL_TXF   = 2;
    localparam int CTRL_RXA   = 1;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_FLUSH = 0;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_LOW,
        TX_HIGH
    } tx_state_e;

endpackage

// File: rtl/sdr_fifo_port_if.sv
// CPU-side register bus of the serial port: one-cycle accesses
// qualified by cs, direction by RW.
interface sdr_fifo_port_if;
    logic       cs;
    logic       RW;
    logic [1:0] A;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;

    modport master (
        output cs, RW, A, d_in,
        input  d_out, d_oe
    );

    modport slave (
        input  cs, RW, A, d_in,
        output d_out, d_oe
    );
endinterface

// File: rtl/sdr_sync_fifo.sv
// Single-clock FIFO with synchronous clear; a pop frees the slot
// that a same-cycle push may use, so push-on-full succeeds then.
module sdr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr)
            r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/sdr_fifo_port.sv
// FIFO-buffered CNT/SP serial port: register file, TX shifter FSM
// with half-bit divider, RX synchroniser/shifter and IRQ logic.
module sdr_fifo_port
    import sdr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4,
    parameter int DIV_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            E_CLK,
    input  logic            RESET_n,
    sdr_fifo_port_if.slave  bus,
    input  logic            cnt_in,
    output logic            cnt_oe,
    input  logic            sp_in,
    output logic            sp_oe,
    output logic            irq_n
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_dir_out;
    logic             r_irq_en;
    logic             r_done;
    logic             r_rx_ovf;
    logic             r_irq_n;
    logic             r_cnt_oe;
    logic             r_sp_oe;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    tx_state_e        r_tx_state;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-1:0] r_rx_sh;
    logic [CW-1:0]    r_tx_bit;
    logic [CW-1:0]    r_rx_bit;
    logic             r_cnt_s1;
    logic             r_cnt_s2;
    logic             r_cnt_s3;
    logic             r_sp_s1;
    logic             r_sp_s2;

    logic             w_wr;
    logic             w_rd;
    logic             w_data_wr;
    logic             w_ctrl_wr;
    logic             w_div_wr;
    logic             w_data_rd;
    logic             w_flush;
    logic             w_tx_pop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [WIDTH-1:0] w_tx_head;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [WIDTH-1:0] w_rx_head;
    logic [WIDTH-1:0] w_rx_next;
    logic [WIDTH-1:0] w_tx_next;
    logic             w_head_bit;
    logic             w_next_bit;
    logic             w_half_end;
    logic             w_frame_end;
    logic             w_cnt_rise;
    logic             w_done_set;
    logic             w_ovf_set;
    logic             w_irq;
    logic             w_busy;
    logic [7:0]       w_rdata;

    assign w_wr      = bus.cs && !bus.RW;
    assign w_rd      = bus.cs && bus.RW;
    assign w_data_wr = w_wr && (bus.A == ADDR_DATA);
    assign w_ctrl_wr = w_wr && (bus.A == ADDR_CTRL);
    assign w_div_wr  = w_wr && (bus.A == ADDR_DIV);
    assign w_data_rd = w_rd && (bus.A == ADDR_DATA);

    // Any direction change restarts both paths from a clean frame.
    assign w_flush = w_ctrl_wr &&
                     (bus.d_in[CTRL_FLUSH] ||
                      (bus.d_in[CTRL_DIR] != r_dir_out));

    assign w_tx_next  = MSB_FIRST ? (r_tx_sh << 1) : (r_tx_sh >> 1);
    assign w_head_bit = MSB_FIRST ? w_tx_head[WIDTH-1] : w_tx_head[0];
    assign w_next_bit = MSB_FIRST ? w_tx_next[WIDTH-1] : w_tx_next[0];
    assign w_half_end = (r_div_cnt == '0);
    assign w_frame_end = (r_tx_state == TX_HIGH) && w_half_end &&
                         (r_tx_bit == LAST);
    assign w_tx_pop = (r_tx_state == TX_LOAD) ||
                      (w_frame_end && !w_tx_empty);

    assign w_rx_next = MSB_FIRST ?
        ((r_rx_sh << 1) | WIDTH'(r_sp_s2)) :
        ((r_rx_sh >> 1) | (WIDTH'(r_sp_s2) << (WIDTH - 1)));
    assign w_cnt_rise = !r_dir_out && r_cnt_s2 && !r_cnt_s3 && !w_flush;
    assign w_rx_push  = w_cnt_rise && (r_rx_bit == LAST);
    assign w_rx_pop   = w_data_rd && !w_rx_empty;

    assign w_done_set = (w_frame_end && !w_flush) || w_rx_push;
    assign w_ovf_set  = w_rx_push && w_rx_full && !w_rx_pop;
    assign w_irq      = r_irq_en && (r_done || r_rx_ovf);
    assign w_busy     = r_dir_out ?
                        ((r_tx_state != TX_IDLE) || !w_tx_empty) :
                        (r_rx_bit != '0);

    sdr_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (E_CLK),
        .i_rst_n (RESET_n),
        .i_clr   (w_flush),
        .i_push  (w_data_wr),
        .i_pop   (w_tx_pop),
        .i_din   (bus.d_in[WIDTH-1:0]),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sdr_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (E_CLK),
        .i_rst_n (RESET_n),
        .i_clr   (w_flush),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (w_rx_next),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_comb begin
        w_rdata = '0;
        case (bus.A)
            ADDR_DATA: begin
                if (!w_rx_empty)
                    w_rdata = 8'(w_rx_head);
            end
            ADDR_CTRL: begin
                w_rdata[CTRL_IRQ]  = w_irq;
                w_rdata[CTRL_DIR]  = r_dir_out;
                w_rdata[CTRL_IEN]  = r_irq_en;
                w_rdata[CTRL_DONE] = r_done;
                w_rdata[CTRL_OVF]  = r_rx_ovf;
                w_rdata[CTRL_TXF]  = w_tx_full;
                w_rdata[CTRL_RXA]  = !w_rx_empty;
                w_rdata[CTRL_BUSY] = w_busy;
            end
            ADDR_DIV: w_rdata = 8'(r_div);
            default:  w_rdata = '0;
        endcase
    end

    assign bus.d_out = w_rd ? w_rdata : 8'h00;
    assign bus.d_oe  = w_rd;
    assign cnt_oe    = r_cnt_oe;
    assign sp_oe     = r_sp_oe;
    assign irq_n     = r_irq_n;

    always_ff @(posedge E_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_dir_out <= 1'b0;
            r_irq_en  <= 1'b0;
            r_div     <= '0;
            r_done    <= 1'b0;
            r_rx_ovf  <= 1'b0;
            r_irq_n   <= 1'b1;
        end else begin
            r_irq_n <= !w_irq;
            if (w_div_wr)
                r_div <= bus.d_in[DIV_W-1:0];
            if (w_ctrl_wr) begin
                r_dir_out <= bus.d_in[CTRL_DIR];
                r_irq_en  <= bus.d_in[CTRL_IEN];
                r_done    <= 1'b0;
                r_rx_ovf  <= 1'b0;
            end
            // A completing frame wins over a same-cycle clear.
            if (w_done_set)
                r_done <= 1'b1;
            if (w_ovf_set)
                r_rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge E_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_tx_state <= TX_IDLE;
            r_div_cnt  <= '0;
            r_tx_sh    <= '0;
            r_tx_bit   <= '0;
            r_cnt_oe   <= 1'b0;
            r_sp_oe    <= 1'b0;
        end else if (w_flush) begin
            r_tx_state <= TX_IDLE;
            r_div_cnt  <= '0;
            r_tx_bit   <= '0;
            r_cnt_oe   <= 1'b0;
            r_sp_oe    <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_dir_out && !w_tx_empty)
                        r_tx_state <= TX_LOAD;
                end
                TX_LOAD: begin
                    r_tx_sh    <= w_tx_head;
                    r_tx_bit   <= '0;
                    r_div_cnt  <= r_div;
                    r_cnt_oe   <= 1'b1;
                    r_sp_oe    <= !w_head_bit;
                    r_tx_state <= TX_LOW;
                end
                TX_LOW: begin
                    if (w_half_end) begin
                        r_div_cnt  <= r_div;
                        r_cnt_oe   <= 1'b0;
                        r_tx_state <= TX_HIGH;
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                TX_HIGH: begin
                    if (!w_half_end) begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end else if (r_tx_bit != LAST) begin
                        r_tx_bit   <= r_tx_bit + 1'b1;
                        r_tx_sh    <= w_tx_next;
                        r_sp_oe    <= !w_next_bit;
                        r_cnt_oe   <= 1'b1;
                        r_div_cnt  <= r_div;
                        r_tx_state <= TX_LOW;
                    end else if (!w_tx_empty) begin
                        // Next word goes straight to LOW: no gap cycle.
                        r_tx_sh    <= w_tx_head;
                        r_tx_bit   <= '0;
                        r_div_cnt  <= r_div;
                        r_cnt_oe   <= 1'b1;
                        r_sp_oe    <= !w_head_bit;
                        r_tx_state <= TX_LOW;
                    end else begin
                        r_sp_oe    <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Sync flops reset to the released (high) pin level so that
    // leaving reset does not look like a CNT rising edge.
    always_ff @(posedge E_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt_s1 <= 1'b1;
            r_cnt_s2 <= 1'b1;
            r_cnt_s3 <= 1'b1;
            r_sp_s1  <= 1'b1;
            r_sp_s2  <= 1'b1;
            r_rx_sh  <= '0;
            r_rx_bit <= '0;
        end else begin
            r_cnt_s1 <= cnt_in;
            r_cnt_s2 <= r_cnt_s1;
            r_cnt_s3 <= r_cnt_s2;
            r_sp_s1  <= sp_in;
            r_sp_s2  <= r_sp_s1;
            if (w_flush) begin
                r_rx_sh  <= '0;
                r_rx_bit <= '0;
            end else if (w_cnt_rise) begin
                r_rx_sh  <= w_rx_next;
                r_rx_bit <= (r_rx_bit == LAST) ? '0 : r_rx_bit + 1'b1;
            end
        end
    end

endmodule
